ex_div: RTL and testbench

- Iterative RV64M divide/remainder unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered ALU operands, funct3, word flag and rd address for DIV/DIVU/REM/REMU and their W forms.
- Produces a 64-bit writeback result.
- Asserts a hold request so the pipeline stalls, via hold_n, while the divide runs.

---
 rtl/ex_div_if.sv | 28 ++
 rtl/ex_div.sv | 169 ++++++++++++++++
 tb/tb_ex_div.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Request/response bundle between the ID/EX register and the iterative divide unit.
// The master side drives the request and the slave side returns the result.
interface ex_div_if #(
  parameter int DW = 64
);
  logic          start_i;
  logic [2:0]    funct3_i;
  logic          word_i;
  logic [DW-1:0] op_num1_i;
  logic [DW-1:0] op_num2_i;
  logic [4:0]    addr_rd_i;
  logic          flush_i;
  logic          hold_req_o;
  logic          done_o;
  logic [DW-1:0] result_o;
  logic [4:0]    addr_rd_o;
  logic          reg_wr_en_o;

  modport master (
    output start_i, funct3_i, word_i, op_num1_i, op_num2_i, addr_rd_i, flush_i,
    input  hold_req_o, done_o, result_o, addr_rd_o, reg_wr_en_o
  );

  modport slave (
    input  start_i, funct3_i, word_i, op_num1_i, op_num2_i, addr_rd_i, flush_i,
    output hold_req_o, done_o, result_o, addr_rd_o, reg_wr_en_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative RV64M DIV/DIVU/REM/REMU (and W forms): restoring radix-2, one quotient bit
// per cycle. Divide-by-zero and signed overflow finish one cycle after the request.
module ex_div #(
  parameter int DW = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  ex_div_if.slave bus
);

  localparam int            CW       = $clog2(DW);
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_rem_sel;
  logic          r_word;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [4:0]    r_rd;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_dsr;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_result;
  logic [4:0]    r_addr_rd_o;
  logic          r_done;

  function automatic logic [DW-1:0] sext32(input logic [DW-1:0] v);
    return {{(DW-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [DW-1:0] zext32(input logic [DW-1:0] v);
    return {{(DW-32){1'b0}}, v[31:0]};
  endfunction

  logic          w_signed;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic          w_sign1;
  logic          w_sign2;
  logic [DW-1:0] w_abs1;
  logic [DW-1:0] w_abs2;
  logic          w_div_zero;
  logic          w_ovf;
  logic [DW-1:0] w_spec_res;

  // Request decode: operand extension, magnitudes and the one-cycle special results.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    w_signed   = ~bus.funct3_i[0];
    w_op1      = bus.op_num1_i;
    w_op2      = bus.op_num2_i;
    if (bus.word_i) begin
      w_op1 = w_signed ? sext32(bus.op_num1_i) : zext32(bus.op_num1_i);
      w_op2 = w_signed ? sext32(bus.op_num2_i) : zext32(bus.op_num2_i);
    end
    w_sign1    = w_signed & w_op1[DW-1];
    w_sign2    = w_signed & w_op2[DW-1];
    w_abs1     = w_sign1 ? -w_op1 : w_op1;
    w_abs2     = w_sign2 ? -w_op2 : w_op2;
    w_div_zero = (w_op2 == '0);
    w_ovf      = w_signed & (bus.word_i
                 ? (bus.op_num1_i[31:0] == 32'h8000_0000 && bus.op_num2_i[31:0] == 32'hFFFF_FFFF)
                 : (w_op1 == MOST_NEG && w_op2 == '1));
    if (w_div_zero) begin
      w_spec_res = bus.funct3_i[1] ? w_op1 : '1;
    end else begin
      w_spec_res = bus.funct3_i[1] ? '0 : w_op1;
    end
    if (bus.word_i) begin
      w_spec_res = sext32(w_spec_res);
    end
  end

  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_diff;
  logic          w_ge;
  logic [DW-1:0] w_rem_nxt;
  logic [DW-1:0] w_dvd_nxt;
  logic [DW-1:0] w_q_fix;
  logic [DW-1:0] w_r_fix;
  logic [DW-1:0] w_sel;
  logic [DW-1:0] w_calc_res;

  // The shifted partial remainder needs one extra bit: with a divisor >= 2^(DW-1)
  // it can exceed DW bits before the trial subtraction.
  always_comb begin
    w_rem_sh   = {r_rem, r_dvd[DW-1]};
    w_diff     = w_rem_sh - {1'b0, r_dsr};
    w_ge       = (w_rem_sh >= {1'b0, r_dsr});
    w_rem_nxt  = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
    w_dvd_nxt  = {r_dvd[DW-2:0], w_ge};
    w_q_fix    = r_neg_q ? -w_dvd_nxt : w_dvd_nxt;
    w_r_fix    = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    w_sel      = r_rem_sel ? w_r_fix : w_q_fix;
    w_calc_res = r_word ? sext32(w_sel) : w_sel;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem_sel   <= 1'b0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_rd        <= 5'd0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_result    <= '0;
      r_addr_rd_o <= 5'd0;
      r_done      <= 1'b0;
    end else if (bus.flush_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_rem_sel <= bus.funct3_i[1];
            r_word    <= bus.word_i;
            r_rd      <= bus.addr_rd_i;
            r_neg_q   <= w_sign1 ^ w_sign2;
            r_neg_r   <= w_sign1;
            r_dvd     <= w_abs1;
            r_dsr     <= w_abs2;
            r_rem     <= '0;
            r_count   <= '0;
            if (w_div_zero || w_ovf) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_result    <= w_spec_res;
              r_addr_rd_o <= bus.addr_rd_i;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_dvd   <= w_dvd_nxt;
          r_rem   <= w_rem_nxt;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(DW-1)) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_result    <= w_calc_res;
            r_addr_rd_o <= r_rd;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Dropping the stall in DONE lets the pipeline advance in the same cycle as writeback.
  assign bus.hold_req_o  = (r_state == IDLE && bus.start_i && !bus.flush_i) || (r_state == CALC);
  assign bus.done_o      = r_done;
  assign bus.reg_wr_en_o = r_done;
  assign bus.result_o    = r_result;
  assign bus.addr_rd_o   = r_addr_rd_o;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table plus flush, reset and back-to-back sequences,
// with results matched through a scoreboard queue as done_o pulses appear.
module tb_ex_div;
  localparam int DW = 64;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [2:0]  f3;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          start_cyc;
    int          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  sb_t  sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ex_div_if #(.DW(DW)) bus ();
  ex_div #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (bus.done_o === 1'b1 || bus.reg_wr_en_o === 1'b1) begin
      check("wr_en_eq_done", {63'b0, bus.reg_wr_en_o}, {63'b0, bus.done_o});
      if (sb.size() == 0) begin
        check("spurious_done", {63'b0, bus.done_o | bus.reg_wr_en_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("addr_rd", {59'b0, bus.addr_rd_o}, {59'b0, e.rd});
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.funct3_i  = v.f3;
    bus.word_i    = v.word;
    bus.op_num1_i = v.a;
    bus.op_num2_i = v.b;
    bus.addr_rd_i = v.rd;
  endtask

  // Wait, bounded, until the scoreboard has drained.
  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, " drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // One request presented for a single cycle; hold_req_o is tracked every cycle until done.
  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    int k;
    @(negedge clk);
    drive(v);
    bus.start_i = 1'b1;
    #1;
    ok = (bus.hold_req_o === 1'b1);
    sb.push_back('{v.exp, v.rd, cyc, v.lat});
    @(negedge clk);
    bus.start_i = 1'b0;
    k = 1;
    forever begin
      #1;
      if (bus.hold_req_o !== (k < v.lat)) ok = 1'b0;
      if (sb.size() == 0) break;
      if (k >= 200) begin
        check({tag, " timeout"}, 64'(sb.size()), 64'd0);
        sb.delete();
        break;
      end
      @(negedge clk);
      k++;
    end
    check({tag, " hold_req"}, {63'b0, ok}, 64'd1);
  endtask

  initial begin
    vec_t va;
    vec_t vb;
    int   c0;

    bus.start_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.funct3_i  = F_DIV;
    bus.word_i    = 1'b0;
    bus.op_num1_i = '0;
    bus.op_num2_i = '0;
    bus.addr_rd_i = 5'd0;

    vecs.push_back('{F_DIV,  1'b0, 64'd100,                64'd7,                  5'd5,  64'd14,                 65});
    vecs.push_back('{F_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  5'd6,  64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  5'd7,  64'h7FFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{F_DIVU, 1'b0, 64'd5,                  64'd0,                  5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{F_REM,  1'b0, 64'd5,                  64'd0,                  5'd9,  64'd5,                  1});
    vecs.push_back('{F_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{F_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0,                  1});
    vecs.push_back('{F_DIV,  1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,                  5'd13, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{F_REMU, 1'b0, 64'd100,                64'd7,                  5'd14, 64'd2,                  65});
    vecs.push_back('{F_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  5'd15, 64'hFFFF_FFFF_FFFF_FFF2, 65});
    vecs.push_back('{F_DIV,  1'b0, 64'd100,                64'hFFFF_FFFF_FFFF_FFF9, 5'd16, 64'hFFFF_FFFF_FFFF_FFF2, 65});
    vecs.push_back('{F_REM,  1'b0, 64'd100,                64'hFFFF_FFFF_FFFF_FFF9, 5'd17, 64'd2,                  65});
    vecs.push_back('{F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'd1,                  65});
    vecs.push_back('{F_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 5'd19, 64'h7FFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 5'd20, 64'h0000_0000_FFFF_FFFF, 65});
    vecs.push_back('{F_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                  5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{F_REMU, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                  5'd22, 64'd1,                  65});
    vecs.push_back('{F_DIV,  1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7,                  5'd23, 64'hFFFF_FFFF_FFFF_FFF2, 65});
    vecs.push_back('{F_DIVU, 1'b1, 64'hABCD_0000_8000_0000, 64'h1234_0000_0000_0000, 5'd24, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{F_REM,  1'b1, 64'h5555_5555_8000_0000, 64'hFFFF_0000_0000_0000, 5'd25, 64'hFFFF_FFFF_8000_0000, 1});

    repeat (3) @(negedge clk);
    #1;
    check("reset done_o", {63'b0, bus.done_o}, 64'd0);
    check("reset reg_wr_en_o", {63'b0, bus.reg_wr_en_o}, 64'd0);
    check("reset result_o", bus.result_o, 64'd0);
    check("reset addr_rd_o", {59'b0, bus.addr_rd_o}, 64'd0);
    check("reset hold_req_o", {63'b0, bus.hold_req_o}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Flush in the middle of CALC, then a fresh request two cycles later.
    va = '{F_DIV, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, 65};
    @(negedge clk);
    drive(va);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (29) @(negedge clk);
    #1;
    check("flush T30 hold", {63'b0, bus.hold_req_o}, 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush T31 hold", {63'b0, bus.hold_req_o}, 64'd0);
    check("flush T31 done", {63'b0, bus.done_o}, 64'd0);
    run_vec('{F_DIV, 1'b0, 64'd1000, 64'd10, 5'd11, 64'd100, 65}, "post_flush");

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    drive('{F_DIVU, 1'b0, 64'd999, 64'd3, 5'd30, 64'd333, 65});
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst done_o", {63'b0, bus.done_o}, 64'd0);
    check("midrst reg_wr_en_o", {63'b0, bus.reg_wr_en_o}, 64'd0);
    check("midrst result_o", bus.result_o, 64'd0);
    check("midrst addr_rd_o", {59'b0, bus.addr_rd_o}, 64'd0);
    check("midrst hold_req_o", {63'b0, bus.hold_req_o}, 64'd0);
    rst_n = 1'b1;
    run_vec('{F_REMU, 1'b0, 64'd1001, 64'd10, 5'd27, 64'd1, 65}, "post_reset");

    // start_i held high: the second request is taken only in the IDLE cycle after DONE,
    // and operands changed during CALC must not disturb the first result.
    va = '{F_DIV,  1'b0, 64'd100, 64'd7, 5'd3, 64'd14, 65};
    vb = '{F_REMU, 1'b0, 64'd200, 64'd9, 5'd4, 64'd2,  65};
    @(negedge clk);
    drive(va);
    bus.start_i = 1'b1;
    #1;
    c0 = cyc;
    sb.push_back('{va.exp, va.rd, c0, 65});
    sb.push_back('{vb.exp, vb.rd, c0 + 66, 65});
    @(negedge clk);
    drive(vb);
    repeat (63) @(negedge clk);
    @(negedge clk);
    #1;
    check("b2b T65 hold", {63'b0, bus.hold_req_o}, 64'd0);
    @(negedge clk);
    #1;
    check("b2b T66 hold", {63'b0, bus.hold_req_o}, 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    drain("b2b");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
